seatbelt_reminder_driver: RTL and testbench

//   Downstream end of the SBL (seatbelt light) request: consumes the SBL request
//   and drives the dashboard lamp and the chime with timed warning behaviour.
//   SBL is synchronized, then a 4-state FSM sequences chime -> flashing lamp -> steady lamp.

---
 rtl/seatbelt_reminder_driver.sv | 167 ++++++++++++++++
 tb/tb_seatbelt_reminder_driver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seatbelt_reminder_driver.sv
// seatbelt_reminder_driver
//   Consumes the seatbelt-light request (SBL) and drives the dashboard lamp and
//   chime. A 2-flop synchronizer feeds a 4-state FSM that steps through three
//   phases: lamp+chime, then flashing lamp, then steady lamp. Timing is derived
//   from a prescaler tick.
// Ports
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   SBL      in   1  seatbelt light request, may be asynchronous to clk
//   lamp     out  1  warning lamp drive, 1 = on
//   chime    out  1  chime drive, 1 = sounding
//   state    out  2  FSM state: 00 IDLE, 01 CHIME, 10 FLASH, 11 HOLD
module seatbelt_reminder_driver #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned CHIME_TICKS = 6,
  parameter int unsigned FLASH_HALF  = 2,
  parameter int unsigned WARN_TICKS  = 90
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SBL,
  output logic       lamp,
  output logic       chime,
  output logic [1:0] state
);

  localparam int unsigned CW       = $clog2(TICK_DIV);
  // The elapsed counter must be able to reach CHIME_TICKS even when
  // WARN_TICKS is smaller, so it saturates at the larger of the two.
  localparam int unsigned ELAP_MAX = (WARN_TICKS > CHIME_TICKS) ? WARN_TICKS : CHIME_TICKS;
  localparam int unsigned EW       = $clog2(ELAP_MAX + 1);
  localparam int unsigned HW       = $clog2(FLASH_HALF + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [EW-1:0] ELAP_SAT   = EW'(ELAP_MAX);
  localparam logic [EW-1:0] CHIME_LAST = EW'(CHIME_TICKS - 1);
  localparam logic [EW-1:0] WARN_LAST  = EW'(WARN_TICKS - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(FLASH_HALF - 1);
  localparam bit            SKIP_FLASH = (WARN_TICKS <= CHIME_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHIME = 2'b01,
    FLASH = 2'b10,
    HOLD  = 2'b11
  } state_e;

  logic          sbl_meta_q;
  logic          sbl_s_q;
  state_e        state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic [HW-1:0] half_q,    half_d;
  logic          phase_q,   phase_d;
  logic          tick;
  logic [EW-1:0] elapsed_inc;

  // Synchronizer: SBL reaches sbl_s_q two edges after it changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbl_meta_q <= 1'b0;
      sbl_s_q    <= 1'b0;
    end else begin
      sbl_meta_q <= SBL;
      sbl_s_q    <= sbl_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      elapsed_q <= '0;
      half_q    <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
    end
  end

  assign tick        = (cnt_q == CNT_LAST);
  assign elapsed_inc = (elapsed_q == ELAP_SAT) ? elapsed_q : elapsed_q + EW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    elapsed_d = tick ? elapsed_inc : elapsed_q;
    half_d    = half_q;
    phase_d   = phase_q;

    if (!sbl_s_q) begin
      // Request withdrawn: drop everything, whatever state we are in.
      state_d   = IDLE;
      cnt_d     = '0;
      elapsed_d = '0;
      half_d    = '0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Clearing the prescaler here puts the first tick exactly
          // TICK_DIV cycles after CHIME entry.
          state_d   = CHIME;
          cnt_d     = '0;
          elapsed_d = '0;
          half_d    = '0;
          phase_d   = 1'b0;
        end
        CHIME: begin
          if (tick && (elapsed_q == CHIME_LAST)) begin
            state_d = SKIP_FLASH ? HOLD : FLASH;
            half_d  = '0;
            phase_d = 1'b1;
          end
        end
        FLASH: begin
          if (tick) begin
            // End of warning window wins over a phase toggle on the same tick.
            if (elapsed_q == WARN_LAST) begin
              state_d = HOLD;
            end else if (half_q == HALF_LAST) begin
              half_d  = '0;
              phase_d = ~phase_q;
            end else begin
              half_d  = half_q + HW'(1);
            end
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          elapsed_d = '0;
          half_d    = '0;
          phase_d   = 1'b0;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so they cannot glitch.
  always_comb begin
    lamp  = 1'b0;
    chime = 1'b0;
    case (state_q)
      CHIME: begin
        lamp  = 1'b1;
        chime = 1'b1;
      end
      FLASH:   lamp = phase_q;
      HOLD:    lamp = 1'b1;
      default: begin
        lamp  = 1'b0;
        chime = 1'b0;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_seatbelt_reminder_driver.sv
module tb_seatbelt_reminder_driver;

  localparam int TD = 4;
  localparam int CT = 3;
  localparam int FH = 2;
  localparam int WT = 11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sbl_a, sbl_b;
  logic       lamp_a, chime_a, lamp_b, chime_b;
  logic [1:0] state_a, state_b;

  always #5 clk = ~clk;

  seatbelt_reminder_driver #(
    .TICK_DIV(TD), .CHIME_TICKS(CT), .FLASH_HALF(FH), .WARN_TICKS(WT)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .SBL(sbl_a),
    .lamp(lamp_a), .chime(chime_a), .state(state_a)
  );

  seatbelt_reminder_driver #(
    .TICK_DIV(TD), .CHIME_TICKS(CT), .FLASH_HALF(FH), .WARN_TICKS(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .SBL(sbl_b),
    .lamp(lamp_b), .chime(chime_b), .state(state_b)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model for dut_a: SBL history plus "edges since the sequence began".
  int hist[$];
  bit m_active;
  int m_t;

  typedef struct {
    int         t;
    logic       lamp;
    logic       chime;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic model_step();
    bit seen;
    if (!reset_n) begin
      hist.delete();
      m_active = 1'b0;
      m_t = 0;
      return;
    end
    hist.push_back(int'(sbl_a));
    if (hist.size() > 3) void'(hist.pop_front());
    seen = (hist.size() == 3) ? (hist[0] != 0) : 1'b0;
    if (!seen) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_t = 0;
    end else begin
      m_t++;
    end
  endtask

  // {lamp, chime, state[1:0]} as a function of time into the sequence.
  function automatic logic [3:0] model_exp();
    int f;
    if (!m_active)           return 4'b0000;
    if (m_t < CT * TD)       return 4'b1101;
    if (WT <= CT)            return 4'b1011;
    if (m_t < WT * TD) begin
      f = (m_t - CT * TD) / (FH * TD);
      return (f % 2 == 0) ? 4'b1010 : 4'b0010;
    end
    return 4'b1011;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_a(input string name, input int l, input int c, input int s);
    chk({name, "_lamp"},  int'(lamp_a),  l);
    chk({name, "_chime"}, int'(chime_a), c);
    chk({name, "_state"}, int'(state_a), s);
  endtask

  initial begin
    int t;
    int remain;
    bit stray;
    bit saw_flash;
    logic [3:0] e;

    tbl[0]  = '{0,   1'b1, 1'b1, 2'b01};
    tbl[1]  = '{11,  1'b1, 1'b1, 2'b01};
    tbl[2]  = '{12,  1'b1, 1'b0, 2'b10};
    tbl[3]  = '{19,  1'b1, 1'b0, 2'b10};
    tbl[4]  = '{20,  1'b0, 1'b0, 2'b10};
    tbl[5]  = '{27,  1'b0, 1'b0, 2'b10};
    tbl[6]  = '{28,  1'b1, 1'b0, 2'b10};
    tbl[7]  = '{36,  1'b0, 1'b0, 2'b10};
    tbl[8]  = '{43,  1'b0, 1'b0, 2'b10};
    tbl[9]  = '{44,  1'b1, 1'b0, 2'b11};
    tbl[10] = '{144, 1'b1, 1'b0, 2'b11};

    // Reset with SBL already asserted
    reset_n = 1'b1;
    sbl_a = 1'b1;
    sbl_b = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_a("rst", 0, 0, 0);
    cycles(3);
    chk_a("rst_held", 0, 0, 0);
    reset_n = 1'b1;
    cycle();
    chk("rel_e1_state", int'(state_a), 0);
    cycle();
    chk("rel_e2_state", int'(state_a), 0);
    cycle();
    t = 0;

    // Full sequence with SBL held high
    foreach (tbl[i]) begin
      while (t < tbl[i].t) begin
        cycle();
        t++;
      end
      chk_a($sformatf("seq_t%0d", tbl[i].t), int'(tbl[i].lamp), int'(tbl[i].chime), int'(tbl[i].st));
    end

    // Drop during CHIME, then re-request
    sbl_a = 1'b0;
    cycles(3);
    chk("idle_after_hold_state", int'(state_a), 0);
    sbl_a = 1'b1;
    cycles(3);
    chk_a("rechime_t0", 1, 1, 1);
    cycles(5);
    sbl_a = 1'b0;
    cycle();
    chk("drop_t6_state", int'(state_a), 1);
    cycle();
    chk_a("drop_t7", 1, 1, 1);
    cycle();
    chk_a("drop_t8", 0, 0, 0);
    sbl_a = 1'b1;
    cycles(3);
    chk_a("restart_t0", 1, 1, 1);
    cycles(11);
    chk_a("restart_t11", 1, 1, 1);
    cycle();
    chk_a("restart_t12", 1, 0, 2);

    // Drop in HOLD
    cycles(32);
    chk_a("hold_t44", 1, 0, 3);
    sbl_a = 1'b0;
    cycles(2);
    chk_a("hold_drop_e2", 1, 0, 3);
    cycle();
    chk_a("hold_drop_e3", 0, 0, 0);

    // Drop in FLASH while lamp is off
    sbl_a = 1'b1;
    cycles(3);
    cycles(20);
    chk_a("flash_off_t20", 0, 0, 2);
    sbl_a = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (lamp_a) stray = 1'b1;
    end
    chk("flash_drop_stray_lamp", int'(stray), 0);
    chk("flash_drop_state", int'(state_a), 0);

    // Drop taking effect on the same edge as the HOLD tick
    sbl_a = 1'b1;
    cycles(3);
    cycles(41);
    chk_a("race_t41", 0, 0, 2);
    sbl_a = 1'b0;
    cycle();
    chk("race_t42_state", int'(state_a), 2);
    cycle();
    chk("race_t43_state", int'(state_a), 2);
    cycle();
    chk_a("race_t44", 0, 0, 0);

    // Warning window shorter than chime: FLASH is skipped
    sbl_b = 1'b1;
    cycles(3);
    chk("skip_t0_state", int'(state_b), 1);
    saw_flash = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (state_b == 2'b10) saw_flash = 1'b1;
      if (i == 11) chk("skip_t11_state", int'(state_b), 1);
      if (i == 12) begin
        chk("skip_t12_state", int'(state_b), 3);
        chk("skip_t12_lamp",  int'(lamp_b),  1);
        chk("skip_t12_chime", int'(chime_b), 0);
      end
    end
    chk("skip_never_flash", int'(saw_flash), 0);
    sbl_b = 1'b0;

    // Reset pulse mid-FLASH
    sbl_a = 1'b1;
    cycles(3);
    cycles(25);
    chk("rstmid_t25_state", int'(state_a), 2);
    reset_n = 1'b0;
    #1 chk_a("rstmid_async", 0, 0, 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    chk_a("rstmid_t0", 1, 1, 1);
    cycles(11);
    chk_a("rstmid_t11", 1, 1, 1);
    cycle();
    chk_a("rstmid_t12", 1, 0, 2);

    // Random SBL against the reference model
    remain = 0;
    for (int i = 0; i < 3000; i++) begin
      if (remain == 0) begin
        sbl_a = 1'($urandom_range(0, 1));
        remain = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 70));
      end
      remain--;
      cycle();
      e = model_exp();
      chk("rand_out", int'({lamp_a, chime_a, state_a}), int'(e));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
